// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests, 2-entry prefetch FIFO, IF/ID register.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_unit #(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [ADDR_W-1:0]  PC_STEP   = ADDR_W'(4),
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hFC00_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc_next,
    output logic [5:0]         opcode
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles,
    output logic [31:0]        perf_flushed
`endif
);

    typedef enum logic {REQ, WAIT} state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  req_pc;
    logic [1:0]         drop_cnt, drop_next, drop_flush;
    logic [INSTR_W-1:0] fifo_instr [2];
    logic [ADDR_W-1:0]  fifo_pc    [2];
    logic               rd_ptr, wr_ptr;
    logic [1:0]         count;

    logic resp_take, stale_resp, live_resp, req_fire, push, pop, lost;

    // drop_cnt counts responses still owed by memory for requests that were flushed
    always_comb begin
        resp_take      = imem_resp_valid && (state == WAIT || drop_cnt != 2'd0);
        stale_resp     = resp_take && drop_cnt != 2'd0;
        live_resp      = resp_take && drop_cnt == 2'd0;
        imem_req_valid = state == REQ && count < 2'd2 && !redirect_valid && !reset;
        imem_req_addr  = pc;
        req_fire       = imem_req_valid && imem_req_ready;
        push           = live_resp && !redirect_valid;
        pop            = !stall && !redirect_valid && count != 2'd0;
        lost           = state == WAIT && !live_resp;
        drop_next      = stale_resp ? drop_cnt - 2'd1 : drop_cnt;
        drop_flush     = drop_next + {1'b0, lost};
        state_next     = state;
        case (state)
            REQ:  if (req_fire)  state_next = WAIT;
            WAIT: if (live_resp) state_next = REQ;
            default: state_next = REQ;
        endcase
        if (redirect_valid) begin
            state_next = REQ;
            drop_next  = drop_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= REQ;
            pc            <= RESET_PC;
            drop_cnt      <= drop_flush;
            count         <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            if_id_valid   <= 1'b0;
            if_id_instr   <= NOP_INSTR;
            if_id_pc      <= '0;
            if_id_pc_next <= '0;
        end else begin
            state    <= state_next;
            drop_cnt <= drop_next;
            if (redirect_valid)
                pc <= redirect_pc;
            else if (req_fire)
                pc <= pc + PC_STEP;

            if (redirect_valid) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= ~wr_ptr;
                if (pop)
                    rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end

            // a redirect forces a bubble even while decode is stalled
            if (redirect_valid || (!stall && count == 2'd0)) begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
            end else if (!stall) begin
                if_id_valid   <= 1'b1;
                if_id_instr   <= fifo_instr[rd_ptr];
                if_id_pc      <= fifo_pc[rd_ptr];
                if_id_pc_next <= fifo_pc[rd_ptr] + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            req_pc <= pc;
        if (!reset && push) begin
            fifo_instr[wr_ptr] <= imem_resp_data;
            fifo_pc[wr_ptr]    <= req_pc;
        end
    end

    assign opcode = if_id_instr[INSTR_W-1 -: 6];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
            perf_flushed <= '0;
        end else begin
            if (pop)
                perf_fetched <= perf_fetched + 32'd1;
            if (!stall && (redirect_valid || count == 2'd0))
                perf_bubbles <= perf_bubbles + 32'd1;
            if (redirect_valid)
                perf_flushed <= perf_flushed + 32'd1 + {30'd0, count} + {31'd0, resp_take};
            else if (stale_resp)
                perf_flushed <= perf_flushed + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with random latency and a
// queue-based reference of the fetch stream, plus directed latency/stall/redirect/reset scenarios.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset, imem_req_valid, imem_req_ready, imem_resp_valid;
    logic        redirect_valid, stall, if_id_valid;
    logic [31:0] imem_req_addr, imem_resp_data, redirect_pc;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_next;
    logic [5:0]  opcode;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(RESET_PC), .PC_STEP(32'd4), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_pc_next(if_id_pc_next), .opcode(opcode)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } memReq_t;

    memReq_t     memQ[$];
    logic [31:0] fifoQ[$];
    int          errors = 0, checks = 0, cyc = 0, respDelay = 1;
    bit          checking = 0, lastAcc = 0, reqSeen = 0, obsReqValid = 0;
    logic [31:0] firstReqAddr = '0, obsReqAddr = '0;
    logic        expValid = 1'b0;
    logic [31:0] expInstr = NOP, expPc = '0, expPcNext = '0, nextFetch = RESET_PC;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0020;
        if (a == 32'h4) return 32'h8C01_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int livePending();
        int n = 0;
        foreach (memQ[i]) if (!memQ[i].stale) n++;
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // one clock cycle: drive inputs and memory response, check request side, then check IF/ID after the edge
    task automatic applyStimulus(input bit rst, input bit rdv, input logic [31:0] rdPc,
                                 input bit stl, input bit rdy);
        bit      showResp, acc, reqExp, pushResp;
        memReq_t head;
        reset          = rst;
        redirect_valid = rdv;
        redirect_pc    = rdPc;
        stall          = stl;
        imem_req_ready = rdy;
        showResp        = memQ.size() > 0 && memQ[0].due <= cyc;
        imem_resp_valid = showResp;
        imem_resp_data  = showResp ? memWord(memQ[0].addr) : 32'hDEAD_BEEF;
        #1;
        reqExp      = !rst && !rdv && livePending() == 0 && fifoQ.size() < 2;
        obsReqValid = imem_req_valid;
        obsReqAddr  = imem_req_addr;
        if (checking) begin
            checkOutput("req_valid", {31'd0, imem_req_valid}, {31'd0, reqExp});
            if (reqExp) checkOutput("req_addr", imem_req_addr, nextFetch);
        end
        if (!rst && imem_req_valid && !reqSeen) begin
            firstReqAddr = imem_req_addr;
            reqSeen      = 1;
        end
        acc     = reqExp && rdy;
        lastAcc = acc;

        @(posedge clk);
        #1;
        cyc++;
        pushResp = 0;
        if (showResp) begin
            head = memQ.pop_front();
            pushResp = !head.stale && !rst && !rdv;
        end
        if (acc) begin
            memQ.push_back('{addr: nextFetch, due: cyc + respDelay - 1, stale: 1'b0});
            nextFetch = nextFetch + 32'd4;
        end
        if (rst || rdv) begin
            expValid = 1'b0;
            expInstr = NOP;
            if (rst) begin
                expPc     = '0;
                expPcNext = '0;
            end
            fifoQ.delete();
            foreach (memQ[i]) memQ[i].stale = 1'b1;
            nextFetch = rst ? RESET_PC : rdPc;
        end else begin
            if (!stl) begin
                if (fifoQ.size() > 0) begin
                    expPc     = fifoQ.pop_front();
                    expValid  = 1'b1;
                    expInstr  = memWord(expPc);
                    expPcNext = expPc + 32'd4;
                end else begin
                    expValid = 1'b0;
                    expInstr = NOP;
                end
            end
            if (pushResp) fifoQ.push_back(head.addr);
        end
        if (rst) checking = 1;
        if (checking) begin
            checkOutput("if_id_valid", {31'd0, if_id_valid}, {31'd0, expValid});
            checkOutput("if_id_instr", if_id_instr, expInstr);
            checkOutput("if_id_pc", if_id_pc, expPc);
            checkOutput("if_id_pc_next", if_id_pc_next, expPcNext);
            checkOutput("opcode", {26'd0, opcode}, {26'd0, expInstr[31:26]});
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;

        // reset, then first words with a 1-cycle memory
        repeat (3) applyStimulus(1, 0, 32'h0, 0, 1);
        checkOutput("reset_valid", {31'd0, if_id_valid}, 32'd0);
        checkOutput("reset_opcode", {26'd0, opcode}, 32'h3F);
        n = 0;
        do begin applyStimulus(0, 0, 32'h0, 0, 1); n++; end while (!if_id_valid && n < 10);
        checkOutput("first_latency", n, 3);
        checkOutput("first_pc", if_id_pc, 32'h0);
        checkOutput("first_opcode", {26'd0, opcode}, 32'h00);
        checkOutput("first_pc_next", if_id_pc_next, 32'h4);
        n = 0;
        do begin applyStimulus(0, 0, 32'h0, 0, 1); n++; end while (!if_id_valid && n < 10);
        checkOutput("second_spacing", n, 2);
        checkOutput("second_pc", if_id_pc, 32'h4);
        checkOutput("second_opcode", {26'd0, opcode}, 32'h23);
        checkOutput("second_pc_next", if_id_pc_next, 32'h8);

        // memory not ready for 5 cycles
        n = 0;
        do begin applyStimulus(0, 0, 32'h0, 0, 0); n++; end while (!obsReqValid && n < 10);
        checkOutput("hold_reached", {31'd0, obsReqValid}, 32'd1);
        begin
            logic [31:0] holdAddr;
            holdAddr = nextFetch;
            repeat (5) begin
                applyStimulus(0, 0, 32'h0, 0, 0);
                checkOutput("hold_valid", {31'd0, obsReqValid}, 32'd1);
                checkOutput("hold_addr", obsReqAddr, holdAddr);
            end
        end
        applyStimulus(0, 0, 32'h0, 0, 1);
        applyStimulus(0, 0, 32'h0, 0, 1);
        checkOutput("single_req", {31'd0, obsReqValid}, 32'd0);

        // stall fills the FIFO, release drains on consecutive cycles
        repeat (6) applyStimulus(0, 0, 32'h0, 1, 1);
        checkOutput("stall_full_req", {31'd0, obsReqValid}, 32'd0);
        applyStimulus(0, 0, 32'h0, 0, 1);
        checkOutput("release_first", {31'd0, if_id_valid}, 32'd1);
        applyStimulus(0, 0, 32'h0, 0, 1);
        checkOutput("release_second", {31'd0, if_id_valid}, 32'd1);

        // redirect while a slow response is outstanding
        respDelay = 3;
        n = 0;
        do begin applyStimulus(0, 0, 32'h0, 0, 1); n++; end while (!lastAcc && n < 20);
        applyStimulus(0, 1, 32'h100, 0, 1);
        checkOutput("redir_valid", {31'd0, if_id_valid}, 32'd0);
        checkOutput("redir_opcode", {26'd0, opcode}, 32'h3F);
        respDelay = 1;
        reqSeen = 0;
        repeat (10) applyStimulus(0, 0, 32'h0, 0, 1);
        checkOutput("redir_req_addr", firstReqAddr, 32'h100);

        // redirect and stall together with a full FIFO
        repeat (6) applyStimulus(0, 0, 32'h0, 1, 1);
        applyStimulus(0, 1, 32'h200, 1, 1);
        checkOutput("flush_stall_valid", {31'd0, if_id_valid}, 32'd0);
        applyStimulus(0, 0, 32'h0, 0, 1);
        checkOutput("flush_empty", {31'd0, if_id_valid}, 32'd0);

        // reset while waiting on a late response
        respDelay = 4;
        n = 0;
        do begin applyStimulus(0, 0, 32'h0, 0, 1); n++; end while (!lastAcc && n < 20);
        reqSeen = 0;
        applyStimulus(1, 0, 32'h0, 0, 1);
        respDelay = 1;
        repeat (12) applyStimulus(0, 0, 32'h0, 0, 1);
        checkOutput("reset_req_addr", firstReqAddr, RESET_PC);

        // random traffic
        repeat (600) begin
            respDelay = $urandom_range(1, 3);
            applyStimulus(0, ($urandom % 16) == 0, {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                          ($urandom % 4) == 0, ($urandom % 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
